// File: rtl/serial_pkg.sv
// serial_pkg: shared state encodings, idle line level and width helper for the serial transmitter
package serial_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
    localparam logic IDLE_LINE = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/serial_tx_ctrl_if.sv
// serial_tx_ctrl_if: start/busy/done handshake between control logic and the serial transmitter
//   iStart  request to send, iData word to send (master -> slave)
//   oBusy   frame in progress, oDone one-cycle completion pulse (slave -> master)
interface serial_tx_ctrl_if #(parameter int DATA_W = 8);
    logic              iStart;
    logic [DATA_W-1:0] iData;
    logic              oBusy;
    logic              oDone;
    modport master(output iStart, iData, input oBusy, oDone);
    modport slave(input iStart, iData, output oBusy, oDone);
endinterface

// File: rtl/serial_tx_ctrl_timer.sv
// bit_period_timer: counts clocks within one serial bit and flags the last one
//   Clock, Reset  clock and synchronous active-high reset
//   Clear         forces the count back to 0
//   Enable        advances the count
//   Tick          high on the last cycle of each bit period
module bit_period_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Tick
);
    localparam int CW = clog2(CLKS_PER_BIT);
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        Tick    = Enable && (count_q == CW'(CLKS_PER_BIT - 1));
        count_d = (Clear || Tick) ? '0 : Enable ? count_q + 1'b1 : count_q;
    end
    always_ff @(posedge Clock) count_q <= Reset ? '0 : count_d;
endmodule

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: frame sequencer driving start bit, LSB-first data, optional parity, stop bit(s)
//   Clock, Reset  clock and synchronous active-high reset
//   bus           slave side of serial_tx_ctrl_if (iStart, iData in; oBusy, oDone out)
//   oTx           registered serial line, idles high
//   Build option SERIAL_TX_PARITY_EN adds an even-parity bit after the data bits.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    serial_tx_ctrl_if.slave bus,
    output logic            oTx
);
    localparam int IW = clog2(DATA_W) + 1;
    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    bit_period_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (state_q == IDLE),
        .Enable(state_q != IDLE),
        .Tick  (tick)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (bus.iStart) begin
                state_d = START;
                shift_d = bus.iData;
                busy_d  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                par_d   = ^bus.iData;
`endif
            end
            START: if (tick) state_d = DATA;
            DATA: if (tick) begin
                if (idx_q == IW'(DATA_W - 1)) begin
                    idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    shift_d = shift_q >> 1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (tick) begin
                idx_d   = '0;
                state_d = STOP;
            end
`endif
            // The bit index is reused to count stop bits.
            STOP: if (tick) begin
                if (idx_q == IW'(STOP_BITS - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the next state so oTx stays aligned with state changes.
`ifdef SERIAL_TX_PARITY_EN
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
               (state_d == PARITY) ? par_q : IDLE_LINE;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : IDLE_LINE;
`endif
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LINE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    assign oTx       = tx_q;
    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;
endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb_serial_tx_ctrl: directed checks of serial_tx_ctrl in three configurations
module tb_serial_tx_ctrl;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  start = '0;
    logic [15:0] din [3];
    logic        txa, txb, txc;
    int          n_total = 0;
    int          n_pass = 0;
    always #5 Clock = ~Clock;
    serial_tx_ctrl_if #(.DATA_W(8)) if_a();
    serial_tx_ctrl_if #(.DATA_W(8)) if_b();
    serial_tx_ctrl_if #(.DATA_W(1)) if_c();
    assign if_a.iStart = start[0];
    assign if_b.iStart = start[1];
    assign if_c.iStart = start[2];
    assign if_a.iData  = din[0][7:0];
    assign if_b.iData  = din[1][7:0];
    assign if_c.iData  = din[2][0:0];
    serial_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(if_a.slave), .oTx(txa));
    serial_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(if_b.slave), .oTx(txb));
    serial_tx_ctrl #(.DATA_W(1), .CLKS_PER_BIT(2), .STOP_BITS(1)) dut_c (
        .Clock(Clock), .Reset(Reset), .bus(if_c.slave), .oTx(txc));
    wire [2:0] tx_o   = {txc, txb, txa};
    wire [2:0] busy_o = {if_c.oBusy, if_b.oBusy, if_a.oBusy};
    wire [2:0] done_o = {if_c.oDone, if_b.oDone, if_a.oDone};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_chk(input int u, input string tag);
        chk($sformatf("%s u%0d tx", tag, u), {31'd0, tx_o[u]}, 32'd1);
        chk($sformatf("%s u%0d busy", tag, u), {31'd0, busy_o[u]}, 32'd0);
        chk($sformatf("%s u%0d done", tag, u), {31'd0, done_o[u]}, 32'd0);
    endtask

    // Called #1 after an edge: raises iStart so the next edge is E0, then checks every
    // cycle of the frame and the done cycle. poke re-asserts iStart and scrambles iData
    // mid-frame; abort applies reset at that frame cycle and ends the frame early.
    task automatic frame(input int u, input logic [15:0] dat, input int w, input int c,
                         input int s, input bit hold, input int poke, input int abort);
        int          n, b;
        logic        e, par;
        logic [15:0] mask;
        n    = 1 + w + P + s;
        mask = (16'h1 << w) - 16'h1;
        par  = ^(dat & mask);
        start[u] = 1'b1;
        din[u]   = dat;
        step();
        if (!hold) start[u] = 1'b0;
        for (int j = 0; j < n * c; j++) begin
            if (j == abort) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                idle_chk(u, "rst");
                for (int k = 0; k < 60; k++) begin
                    chk($sformatf("post-rst u%0d done c%0d", u, k), {31'd0, done_o[u]}, 32'd0);
                    step();
                end
                return;
            end
            if (j == poke) begin
                start[u] = 1'b1;
                din[u]   = 16'hFFFF;
            end
            if (j == poke + 1) start[u] = 1'b0;
            b = j / c;
            e = (b == 0) ? 1'b0 : (b <= w) ? dat[b-1] : (P == 1 && b == w + 1) ? par : 1'b1;
            chk($sformatf("u%0d tx c%0d", u, j), {31'd0, tx_o[u]}, {31'd0, e});
            chk($sformatf("u%0d busy c%0d", u, j), {31'd0, busy_o[u]}, 32'd1);
            chk($sformatf("u%0d done c%0d", u, j), {31'd0, done_o[u]}, 32'd0);
            step();
        end
        chk($sformatf("u%0d end tx", u), {31'd0, tx_o[u]}, 32'd1);
        chk($sformatf("u%0d end busy", u), {31'd0, busy_o[u]}, 32'd0);
        chk($sformatf("u%0d end done", u), {31'd0, done_o[u]}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) din[i] = '0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) idle_chk(i, "reset");
        Reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) idle_chk(i, "post-reset");
        frame(0, 16'h00A5, 8, 4, 1, 1'b0, -1, -1);
        step();
        idle_chk(0, "after A5");
        frame(0, 16'h0007, 8, 4, 1, 1'b0, -1, -1);
        step();
        idle_chk(0, "after 07");
        frame(0, 16'h005A, 8, 4, 1, 1'b0, 10, -1);
        frame(0, 16'h003C, 8, 4, 1, 1'b0, -1, -1);
        step();
        idle_chk(0, "after 3C");
        frame(0, 16'h00A5, 8, 4, 1, 1'b0, -1, 17);
        frame(0, 16'h00C3, 8, 4, 1, 1'b0, -1, -1);
        step();
        idle_chk(0, "after C3");
        frame(1, 16'h0000, 8, 4, 2, 1'b1, -1, -1);
        frame(1, 16'h0000, 8, 4, 2, 1'b1, -1, -1);
        start[1] = 1'b0;
        step();
        idle_chk(1, "after b2b");
        frame(2, 16'h0001, 1, 2, 1, 1'b0, -1, -1);
        step();
        idle_chk(2, "after c1");
        frame(2, 16'h0000, 1, 2, 1, 1'b0, -1, -1);
        step();
        idle_chk(2, "after c0");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
